// File: rtl/multi_clock_divider.sv
// multi_clock_divider: CHANNELS independent programmable clock dividers.
// Each channel has a divided clock with programmable period and high time,
// and a one-cycle tick on the first cycle of each period. New settings are
// held in a shadow register and take effect only at a period boundary, or
// at once while the channel is disabled.
// Optional feature macro: CLKDIV_PHASE_SYNC_EN adds the sync port. A pulse
// on sync forces a boundary on every enabled channel.
module multi_clock_divider #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 2
) (
  input  logic                      in_clock,
  input  logic                      reset_n,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] divider,
  input  logic [CHANNELS*WIDTH-1:0] high_time,
`ifdef CLKDIV_PHASE_SYNC_EN
  input  logic                      sync,
`endif
  output logic [CHANNELS-1:0]       out_clock,
  output logic [CHANNELS-1:0]       out_tick,
  output logic [CHANNELS-1:0]       pending
);

  logic w_sync;

`ifdef CLKDIV_PHASE_SYNC_EN
  assign w_sync = sync;
`else
  assign w_sync = 1'b0;
`endif

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    // Active settings and position within the current period
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_high;
    // Shadow settings waiting for the next boundary
    logic [WIDTH-1:0] r_pend_period;
    logic [WIDTH-1:0] r_pend_high;
    logic             r_pend_valid;
    // Registered outputs
    logic             r_clk;
    logic             r_tick;

    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] w_period_nxt;
    logic [WIDTH-1:0] w_high_nxt;
    logic [WIDTH-1:0] w_pend_period_nxt;
    logic [WIDTH-1:0] w_pend_high_nxt;
    logic             w_pend_valid_nxt;
    logic             w_clk_nxt;
    logic             w_tick_nxt;
    logic             w_boundary;
    logic             w_apply;

    // Next-state: boundary detection, shadow apply/capture, count and outputs
    always_comb begin
      w_count_nxt       = r_count;
      w_period_nxt      = r_period;
      w_high_nxt        = r_high;
      w_pend_period_nxt = r_pend_period;
      w_pend_high_nxt   = r_pend_high;
      w_pend_valid_nxt  = r_pend_valid;
      w_clk_nxt         = 1'b0;
      w_tick_nxt        = 1'b0;

      w_boundary = enable[gi] && (w_sync || (r_count == r_period));
      // Only settings that were already pending before this edge are applied;
      // a load arriving on the same edge waits for the following boundary.
      w_apply    = r_pend_valid && (w_boundary || !enable[gi]);

      if (w_apply) begin
        w_period_nxt     = r_pend_period;
        w_high_nxt       = r_pend_high;
        w_pend_valid_nxt = 1'b0;
      end else begin
        w_period_nxt     = r_period;
        w_high_nxt       = r_high;
      end

      if (load[gi]) begin
        w_pend_period_nxt = divider[gi*WIDTH +: WIDTH];
        w_pend_high_nxt   = high_time[gi*WIDTH +: WIDTH];
        w_pend_valid_nxt  = 1'b1;
      end else begin
        w_pend_period_nxt = r_pend_period;
        w_pend_high_nxt   = r_pend_high;
      end

      if (!enable[gi]) begin
        // Park at the end of the period so the first enabled edge is a boundary
        w_count_nxt = w_period_nxt;
        w_clk_nxt   = 1'b0;
        w_tick_nxt  = 1'b0;
      end else if (w_boundary) begin
        w_count_nxt = {WIDTH{1'b0}};
        w_clk_nxt   = (w_count_nxt < w_high_nxt);
        w_tick_nxt  = 1'b1;
      end else begin
        // count < period here, so the increment cannot wrap
        w_count_nxt = r_count + {{(WIDTH-1){1'b0}}, 1'b1};
        w_clk_nxt   = (w_count_nxt < w_high_nxt);
        w_tick_nxt  = 1'b0;
      end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge in_clock) begin
      if (!reset_n) begin
        r_count       <= {WIDTH{1'b0}};
        r_period      <= {WIDTH{1'b0}};
        r_high        <= {WIDTH{1'b0}};
        r_pend_period <= {WIDTH{1'b0}};
        r_pend_high   <= {WIDTH{1'b0}};
        r_pend_valid  <= 1'b0;
        r_clk         <= 1'b0;
        r_tick        <= 1'b0;
      end else begin
        r_count       <= w_count_nxt;
        r_period      <= w_period_nxt;
        r_high        <= w_high_nxt;
        r_pend_period <= w_pend_period_nxt;
        r_pend_high   <= w_pend_high_nxt;
        r_pend_valid  <= w_pend_valid_nxt;
        r_clk         <= w_clk_nxt;
        r_tick        <= w_tick_nxt;
      end
    end

    assign out_clock[gi] = r_clk;
    assign out_tick[gi]  = r_tick;
    assign pending[gi]   = r_pend_valid;
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Testbench for multi_clock_divider: a vector table stepped one clock per
// record, a full-range period sequence, and a sync sequence when
// CLKDIV_PHASE_SYNC_EN is defined.
module tb_multi_clock_divider;

  localparam int W = 16;
  localparam int C = 2;

  logic             in_clock;
  logic             reset_n;
  logic [C-1:0]     enable;
  logic [C-1:0]     load;
  logic [C*W-1:0]   divider;
  logic [C*W-1:0]   high_time;
`ifdef CLKDIV_PHASE_SYNC_EN
  logic             sync;
`endif
  logic [C-1:0]     out_clock;
  logic [C-1:0]     out_tick;
  logic [C-1:0]     pending;

  int total;
  int bad;

  multi_clock_divider #(.WIDTH(W), .CHANNELS(C)) dut (
    .in_clock  (in_clock),
    .reset_n   (reset_n),
    .enable    (enable),
    .load      (load),
    .divider   (divider),
    .high_time (high_time),
`ifdef CLKDIV_PHASE_SYNC_EN
    .sync      (sync),
`endif
    .out_clock (out_clock),
    .out_tick  (out_tick),
    .pending   (pending)
  );

  initial in_clock = 1'b0;
  always #5 in_clock = ~in_clock;

  typedef struct {
    logic         rst_n;
    logic [1:0]   en;
    logic [1:0]   ld;
    logic [15:0]  d0;
    logic [15:0]  h0;
    logic [15:0]  d1;
    logic [15:0]  h1;
    logic [1:0]   eclk;
    logic [1:0]   etick;
    logic [1:0]   epend;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic [1:0] en, input logic [1:0] ld,
                     input int d0, input int h0, input int d1, input int h1,
                     input logic [1:0] ck, input logic [1:0] tk, input logic [1:0] pd);
    vec_t v;
    v.rst_n = r; v.en = en; v.ld = ld;
    v.d0 = d0[15:0]; v.h0 = h0[15:0]; v.d1 = d1[15:0]; v.h1 = h1[15:0];
    v.eclk = ck; v.etick = tk; v.epend = pd;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [1:0] act, input logic [1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge in_clock);
    #1;
  endtask

  initial begin
    int n;
    int highs;
    total = 0;
    bad   = 0;
    reset_n = 1'b0; enable = 2'b00; load = 2'b00; divider = '0; high_time = '0;
`ifdef CLKDIV_PHASE_SYNC_EN
    sync = 1'b0;
`endif

    // rst en  ld  d0 h0 d1 h1  clk   tick  pend
    add(0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    add(1, 2'b00, 2'b01, 3, 2, 0, 0, 2'b00, 2'b00, 2'b01);
    add(1, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    add(1, 2'b01, 2'b00, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00);
    add(1, 2'b01, 2'b00, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
    add(1, 2'b01, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    add(1, 2'b01, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    add(1, 2'b01, 2'b00, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00);
    // mid-period load 5/1
    add(1, 2'b01, 2'b01, 5, 1, 0, 0, 2'b01, 2'b00, 2'b01);
    add(1, 2'b01, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01);
    add(1, 2'b01, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01);
    add(1, 2'b01, 2'b00, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00);
    for (int i = 0; i < 5; i++) add(1, 2'b01, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    add(1, 2'b01, 2'b00, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00);
    // disabled load of 0/1 applies immediately
    add(1, 2'b00, 2'b01, 0, 1, 0, 0, 2'b00, 2'b00, 2'b01);
    add(1, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    add(1, 2'b01, 2'b00, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00);
    add(1, 2'b01, 2'b00, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00);
    // high=0, loaded on a boundary edge
    add(1, 2'b01, 2'b01, 0, 0, 0, 0, 2'b01, 2'b01, 2'b01);
    add(1, 2'b01, 2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00);
    add(1, 2'b01, 2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00);
    // high=9 > divider=3
    add(1, 2'b01, 2'b01, 3, 9, 0, 0, 2'b00, 2'b01, 2'b01);
    add(1, 2'b01, 2'b00, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00);
    for (int i = 0; i < 3; i++) add(1, 2'b01, 2'b00, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
    add(1, 2'b01, 2'b00, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00);
    add(1, 2'b01, 2'b00, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
    // reset mid-period with enable held, then run with cleared settings
    add(0, 2'b01, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    add(1, 2'b01, 2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00);
    add(1, 2'b01, 2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00);
    // ch1 set to 3/1 and started
    add(1, 2'b01, 2'b10, 0, 0, 3, 1, 2'b00, 2'b01, 2'b10);
    add(1, 2'b01, 2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00);
    add(1, 2'b11, 2'b00, 0, 0, 0, 0, 2'b10, 2'b11, 2'b00);
    // two loads (7 then 2) before the boundary: latest wins
    add(1, 2'b11, 2'b10, 0, 0, 7, 1, 2'b00, 2'b01, 2'b10);
    add(1, 2'b11, 2'b10, 0, 0, 2, 1, 2'b00, 2'b01, 2'b10);
    add(1, 2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10);
    add(1, 2'b11, 2'b00, 0, 0, 0, 0, 2'b10, 2'b11, 2'b00);
    add(1, 2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00);
    add(1, 2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00);
    add(1, 2'b11, 2'b00, 0, 0, 0, 0, 2'b10, 2'b11, 2'b00);
    add(1, 2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00);
    add(1, 2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00);
    // load on the boundary edge waits one more period
    add(1, 2'b11, 2'b10, 0, 0, 4, 2, 2'b10, 2'b11, 2'b10);
    add(1, 2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10);
    add(1, 2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10);
    add(1, 2'b11, 2'b00, 0, 0, 0, 0, 2'b10, 2'b11, 2'b00);
    add(1, 2'b11, 2'b00, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00);
    for (int i = 0; i < 3; i++) add(1, 2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00);
    add(1, 2'b11, 2'b00, 0, 0, 0, 0, 2'b10, 2'b11, 2'b00);
    // enable fall then rise on ch1
    add(1, 2'b01, 2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00);
    add(1, 2'b11, 2'b00, 0, 0, 0, 0, 2'b10, 2'b11, 2'b00);

    foreach (vq[i]) begin
      reset_n   = vq[i].rst_n;
      enable    = vq[i].en;
      load      = vq[i].ld;
      divider   = {vq[i].d1, vq[i].d0};
      high_time = {vq[i].h1, vq[i].h0};
      step();
      check("clk",  i, out_clock, vq[i].eclk);
      check("tick", i, out_tick,  vq[i].etick);
      check("pend", i, pending,   vq[i].epend);
    end

    // Full-range period: divider=FFFF gives 65536 cycles, high=8000
    enable = 2'b01; load = 2'b01;
    divider = {16'h0000, 16'hFFFF}; high_time = {16'h0000, 16'h8000};
    step();
    load = 2'b00;
    step();
    check("full_start_tick", 0, out_tick, 2'b01);
    highs = (out_clock[0] === 1'b1) ? 1 : 0;
    n = 0;
    for (int k = 1; k <= 70000; k++) begin
      step();
      if (out_tick[0] === 1'b1) begin
        n = k;
        break;
      end else if (out_clock[0] === 1'b1) begin
        highs++;
      end else begin
        highs = highs;
      end
    end
    total++;
    if (n != 65536) begin
      bad++;
      $display("FAIL full_period: got %0d expected 65536", n);
    end
    total++;
    if (highs != 32768) begin
      bad++;
      $display("FAIL full_high: got %0d expected 32768", highs);
    end

`ifdef CLKDIV_PHASE_SYNC_EN
    // Sync aligns two channels with different periods
    reset_n = 1'b0; enable = 2'b00; load = 2'b00;
    step();
    reset_n = 1'b1; load = 2'b11;
    divider = {16'd5, 16'd3}; high_time = {16'd1, 16'd1};
    step();
    load = 2'b00;
    step();
    enable = 2'b01;
    step(); step(); step();
    enable = 2'b11;
    step(); step(); step();
    sync = 1'b1;
    step();
    check("sync_tick", 0, out_tick, 2'b11);
    check("sync_clk",  0, out_clock, 2'b11);
    sync = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      check("sync_after_tick", k, out_tick, 2'b00);
      check("sync_after_clk",  k, out_clock, 2'b00);
    end
    step();
    check("sync_ch0_wrap_tick", 4, out_tick, 2'b01);
    check("sync_ch0_wrap_clk",  4, out_clock, 2'b01);
    // Disabled channel ignores sync
    enable = 2'b01; sync = 1'b1;
    step();
    check("sync_dis_tick", 0, out_tick, 2'b01);
    check("sync_dis_clk",  0, out_clock, 2'b01);
    // Reset wins over sync
    enable = 2'b11; reset_n = 1'b0;
    step();
    check("sync_rst_tick", 0, out_tick, 2'b00);
    check("sync_rst_clk",  0, out_clock, 2'b00);
    sync = 1'b0; reset_n = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
